// File: rtl/add_cla_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor built from 4-bit groups.
// Stage 1 registers the group propagate/generate terms; stage 2 resolves the carries and registers the result and flags.
module add_cla_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / 4;

  logic             s1_valid;
  logic             s1_adv;
  logic             s2_adv;

  logic [WIDTH-1:0] bx_d;
  logic             c0_d;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] g_d;
  logic [NG-1:0]    gp_d;
  logic [NG-1:0]    gg_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;
  logic             c0_q;
  logic [WIDTH-1:0] p_q;
  logic [NG-1:0]    gp_q;
  logic [NG-1:0]    gg_q;

  logic [WIDTH-1:0] g_q;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Operand conditioning and per-group propagate/generate.
  always_comb begin
    bx_d = op[1] ? ~b : b;
    case (op)
      2'b00:   c0_d = 1'b0;
      2'b10:   c0_d = 1'b1;
      default: c0_d = cin;
    endcase
    p_d  = a ^ bx_d;
    g_d  = a & bx_d;
    gp_d = '0;
    gg_d = '0;
    for (int k = 0; k < NG; k++) begin
      gp_d[k] = &p_d[4*k +: 4];
      gg_d[k] = g_d[4*k+3]
              | (p_d[4*k+3] & g_d[4*k+2])
              | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
              | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k]);
    end
  end

  // Group-level lookahead, then 4-bit lookahead inside each group from its carry-in.
  always_comb begin
    g_q   = a_q & bx_q;
    gc    = '0;
    c     = '0;
    gc[0] = c0_q;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = gg_q[k] | (gp_q[k] & gc[k]);
    end
    for (int k = 0; k < NG; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g_q[4*k] | (p_q[4*k] & gc[k]);
      c[4*k+2] = g_q[4*k+1]
               | (p_q[4*k+1] & g_q[4*k])
               | (p_q[4*k+1] & p_q[4*k] & gc[k]);
      c[4*k+3] = g_q[4*k+2]
               | (p_q[4*k+2] & g_q[4*k+1])
               | (p_q[4*k+2] & p_q[4*k+1] & g_q[4*k])
               | (p_q[4*k+2] & p_q[4*k+1] & p_q[4*k] & gc[k]);
    end
    sum_d = p_q ^ c;
    ovf_d = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      a_q      <= '0;
      bx_q     <= '0;
      c0_q     <= 1'b0;
      p_q      <= '0;
      gp_q     <= '0;
      gg_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      // Data only moves on an accepted beat so idle inputs are never sampled.
      if (in_valid) begin
        a_q  <= a;
        bx_q <= bx_d;
        c0_q <= c0_d;
        p_q  <= p_d;
        gp_q <= gp_d;
        gg_q <= gg_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        s    <= sum_d;
        cout <= gc[NG];
        ovf  <= ovf_d;
        zero <= (sum_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_add_cla_pipe.sv
// Scoreboard bench: directed 32-bit vectors with hand-computed results, plus
// exhaustive 8-bit runs (one instance per op/cin mode) against an arithmetic model.
module tb_add_cla_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [1:0]  op;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        cout, ovf, zero;

  logic        in_valid8;
  logic [7:0]  a8, b8;
  logic [1:0]  op8  [6];
  logic        cin8 [6];
  logic [5:0]  in_ready8, out_valid8, cout8, ovf8, zero8;
  logic [7:0]  s8   [6];
  logic        out_ready8;
  logic [65:0] act8;

  int checks = 0;
  int errors = 0;
  int rcv8   = 0;

  logic [34:0] exp_q [$];
  logic [65:0] exp8_q [$];

  always #5 clk = ~clk;

  add_cla_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  for (genvar gi = 0; gi < 6; gi++) begin : g8
    add_cla_pipe #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8[gi]),
      .a(a8), .b(b8), .op(op8[gi]), .cin(cin8[gi]),
      .out_valid(out_valid8[gi]), .out_ready(out_ready8),
      .s(s8[gi]), .cout(cout8[gi]), .ovf(ovf8[gi]), .zero(zero8[gi])
    );
  end

  always_comb begin
    act8 = '0;
    for (int i = 0; i < 6; i++)
      act8[i*11 +: 11] = {s8[i], cout8[i], ovf8[i], zero8[i]};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [10:0] model8(input logic [7:0] av, input logic [7:0] bv,
                                         input logic [1:0] opv, input logic cv);
    logic [7:0] bxv;
    logic       c0v;
    logic [8:0] sum9;
    logic       ov;
    bxv  = opv[1] ? ~bv : bv;
    c0v  = (opv == 2'b10) ? 1'b1 : (opv == 2'b00) ? 1'b0 : cv;
    sum9 = {1'b0, av} + {1'b0, bxv} + {8'd0, c0v};
    ov   = (av[7] == bxv[7]) && (sum9[7] != av[7]);
    return {sum9[7:0], sum9[8], ov, sum9[7:0] == 8'd0};
  endfunction

  // 32-bit scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected32 actual=%0h required=none", {s, cout, ovf, zero});
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        if ({s, cout, ovf, zero} !== e) begin
          errors++;
          $display("FAIL result32 actual s=%h c=%b v=%b z=%b required s=%h c=%b v=%b z=%b",
                   s, cout, ovf, zero, e[34:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // 8-bit scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid8[0]) begin
      checks++;
      rcv8++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected8 actual=%0h required=none", act8);
      end else begin
        logic [65:0] e8;
        e8 = exp8_q.pop_front();
        if ({out_valid8, act8} !== {6'h3f, e8}) begin
          errors++;
          $display("FAIL result8 a=%h b=%h actual=%h required=%h", a8, b8,
                   {out_valid8, act8}, {6'h3f, e8});
        end
      end
    end
  end

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [1:0] opv,
                      input logic cv, input logic [31:0] sv, input logic co,
                      input logic ov, input logic zr);
    a = av; b = bv; op = opv; cin = cv; in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({sv, co, ov, zr});
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout actual=in_ready_low required=accept");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [34:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0; cin = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    op8[0] = 2'b00; cin8[0] = 1'b0;
    op8[1] = 2'b01; cin8[1] = 1'b0;
    op8[2] = 2'b01; cin8[2] = 1'b1;
    op8[3] = 2'b10; cin8[3] = 1'b0;
    op8[4] = 2'b11; cin8[4] = 1'b0;
    op8[5] = 2'b11; cin8[5] = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_flags", {29'd0, s, cout, ovf, zero}, 64'd0);
    rst = 1'b0;
    #1 chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Add wrap with latency check
    send(32'hFFFFFFFF, 32'h00000001, 2'b00, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    chk("latency_edge_n", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 chk("latency_edge_n1", 64'(out_valid), 64'd1);
    drain();

    // Back-to-back directed vectors
    send(32'h80000000, 32'h00000001, 2'b10, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    send(32'h00000005, 32'h00000007, 2'b10, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    send(32'h7FFFFFFF, 32'h00000000, 2'b01, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0);
    send(32'h00000010, 32'h00000003, 2'b11, 1'b0, 32'h0000000C, 1'b1, 1'b0, 1'b0);
    drain();

    // Backpressure: five beats, consumer stalls for three cycles
    @(posedge clk);
    #1;
    fork
      begin
        send(32'h00000001, 32'h00000002, 2'b00, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0);
        send(32'h0000FFFF, 32'h00000001, 2'b00, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
        send(32'hFFFFFFFE, 32'h00000001, 2'b00, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        send(32'h12345678, 32'h11111111, 2'b00, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0);
        send(32'h0000000A, 32'h0000000A, 2'b10, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held = {s, cout, ovf, zero};
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_held_first", 64'(held), {29'd0, 32'h00000003, 3'b000});
        repeat (2) begin
          @(posedge clk);
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          chk("stall_hold", {29'd0, s, cout, ovf, zero}, {29'd0, held});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        #1 chk("pop_push_in_ready", 64'(in_ready), 64'd1);
      end
    join
    drain();

    // Asynchronous reset with two beats in flight
    send(32'h00000100, 32'h00000001, 2'b00, 1'b0, 32'h00000101, 1'b0, 1'b0, 1'b0);
    send(32'h00000200, 32'h00000002, 2'b00, 1'b0, 32'h00000202, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_s", {29'd0, s, cout, ovf, zero}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_result", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(32'hDEADBEEF, 32'h00000001, 2'b00, 1'b0, 32'hDEADBEF0, 1'b0, 1'b0, 1'b0);
    drain();

    // Exhaustive 8-bit lookahead over all op/cin modes
    chk("rdy8", 64'(in_ready8), 64'h3f);
    in_valid8 = 1'b1;
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 256; bi++) begin
        logic [65:0] e8;
        a8 = 8'(ai);
        b8 = 8'(bi);
        for (int i = 0; i < 6; i++)
          e8[i*11 +: 11] = model8(a8, b8, op8[i], cin8[i]);
        @(negedge clk);
        exp8_q.push_back(e8);
        @(posedge clk);
        #1;
      end
    end
    in_valid8 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (exp8_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("rcv8_count", 64'(rcv8), 64'd65536);
    chk("exp8_empty", 64'(exp8_q.size()), 64'd0);
    chk("exp32_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_cla_pipe.md
# add_cla_pipe

Parametrised, two-stage pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, each producing group propagate (GP) and group generate (GG). It extends the 4-bit group adder and the 32-bit adder assembled from it with configurable width, add/subtract/carry modes, status flags and a valid/ready stream handshake. It sits between operand-issue logic and a result consumer that may apply backpressure.

## Interface
- WIDTH, 32: operand/result width; multiple of 4, range 4..64; number of groups NG = WIDTH/4.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00 add, 01 add with carry, 10 subtract, 11 subtract with borrow.
- cin  in  1  carry-in; used only for op 01/11.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  out  1  two's-complement overflow.
- zero  out  1  s == 0.

## Operation
- Effective operand: bx = op[1] ? ~b : b. Carry-in: c0 = 1 for op 10, 0 for op 00, cin for op 01/11.
- s = a + bx + c0, computed modulo 2^WIDTH; cout = bit WIDTH of the (WIDTH+1)-bit sum.
- Stage 1 register holds a, bx, c0, bit p = a^bx, and per group k: GP[k] = AND of the group's p bits, GG[k] = g3 | p3g2 | p3p2g1 | p3p2p1g0 with g = a&bx.
- Stage 2 logic: group carries C[0] = c0, C[k+1] = GG[k] | GP[k]&C[k] (lookahead over groups); in-group carries by 4-bit lookahead from C[k]; s_i = p_i ^ c_i.
- Stage 2 register holds s, cout, ovf = (a[W-1] == bx[W-1]) & (s[W-1] != a[W-1]), and zero.
- Handshake: a beat transfers on in_valid & in_ready; a result transfers on out_valid & out_ready.
- s2_adv = !out_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational from out_ready).
- Stage 1 loads when s1_adv. Its valid bit becomes in_valid & in_ready. Stage 2 loads when s2_adv, taking stage 1's valid bit.
- Stalled stages hold all data bits unchanged. Inputs a, b, op and cin are not sampled unless accepted.
- Results leave in acceptance order; none are dropped or duplicated. Capacity is 2 beats.

## Timing
- Reset (asynchronous, immediate): out_valid = 0, s1_valid = 0, s = 0, cout = 0, ovf = 0, zero = 0. in_ready = 1 once rst is low.
- Latency: a beat accepted at edge N gives out_valid = 1 after edge N+1, provided no stall.
- Throughput: 1 beat per cycle while out_ready = 1.
- Full: with both stages valid and out_ready = 0, in_ready = 0. Raising out_ready re-enables in_ready in the same cycle, so a simultaneous pop and push both happen.
- Outputs s, cout, ovf and zero are registered. They stay stable while out_valid & !out_ready.
- Reset mid-operation discards both in-flight beats. The first beat after reset completes normally.

## Test plan
- Reset: assert rst asynchronously while 2 beats are in flight -> out_valid drops immediately, s = 0; after release in_ready = 1, no stale result appears.
- Add wrap (WIDTH=32): a=FFFFFFFF, b=00000001, op=00 -> s=00000000, cout=1, zero=1, ovf=0; out_valid 2 cycles after accept.
- Subtract overflow: a=80000000, b=00000001, op=10 -> s=7FFFFFFF, cout=1, ovf=1. Second case: a=5, b=7, op=10 -> s=FFFFFFFE, cout=0, ovf=0.
- Carry modes: a=7FFFFFFF, b=0, op=01, cin=1 -> s=80000000, ovf=1. Second case: a=10, b=3, op=11, cin=0 -> s=0000000C, cout=1.
- Backpressure: stream 5 beats with out_ready low for cycles 2-4 -> in_ready low while full; all 5 results arrive in order with correct values; held outputs do not change during the stall.
- Group lookahead: WIDTH=8 instance, exhaustive a, b in 0..255 for all op/cin combinations, checked against a behavioural model -> zero mismatches. Include the full-propagate chain a=FF, b=00, c0=1.
